// File: rtl/packet_sorter_pkg.sv
// Shared types and constants for the packet sorter.
package packet_sorter_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        SORT = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/packet_sorter_if.sv
// Avalon-ST style streaming bundle; master drives the beat, slave returns ready.
interface packet_sorter_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;

    modport master (output data, startofpacket, endofpacket, valid, input ready);
    modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/packet_sorter_cmp.sv
// Combinational compare-and-swap of one word pair; lo_o is the word that belongs first.
module packet_sorter_cmp
    import packet_sorter_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    input  logic              dir_i,
    output logic [DWIDTH-1:0] lo_o,
    output logic [DWIDTH-1:0] hi_o,
    output logic              swap_o
);

    // Strict compare only, so equal words keep their order.
    always_comb begin
        swap_o = 1'b0;
        lo_o   = a_i;
        hi_o   = b_i;
        if (dir_i == DIR_ASC) begin
            swap_o = (a_i > b_i);
        end else begin
            swap_o = (a_i < b_i);
        end
        if (swap_o) begin
            lo_o = b_i;
            hi_o = a_i;
        end else begin
            lo_o = a_i;
            hi_o = b_i;
        end
    end

endmodule

// File: rtl/packet_sorter.sv
// In-place bubble sorter for one sop/eop framed packet of up to 2**AWIDTH words.
// Optional PACKET_SORTER_EARLY_EXIT_EN: stop after a swap-free pass and report swaps_o.
module packet_sorter
    import packet_sorter_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  dir_i,
    packet_sorter_if.slave        snk_if,
    packet_sorter_if.master       src_if,
    output logic                  busy_o,
    output logic                  ovf_o
`ifdef PACKET_SORTER_EARLY_EXIT_EN
    ,
    output logic [2*AWIDTH-1:0]   swaps_o
`endif
);

    localparam int              DEPTH   = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);

    state_t              state_q;
    logic [DWIDTH-1:0]   mem_q [DEPTH];
    logic [AWIDTH:0]     len_q;
    logic [AWIDTH-1:0]   j_q, pass_q, rd_idx_q;
    logic                dir_q, in_pkt_q, ovf_seen_q, pass_swap_q;
    logic                snk_ready_q, src_valid_q, src_sop_q, src_eop_q, busy_q, ovf_q;
    logic [DWIDTH-1:0]   src_data_q;
`ifdef PACKET_SORTER_EARLY_EXIT_EN
    logic [2*AWIDTH-1:0] swaps_q;
`endif

    logic                accept_s, send_s, pass_end_s, last_pass_s, done_s, swap_s;
    logic [AWIDTH-1:0]   j_nxt_s, wr_idx_s;
    logic [AWIDTH:0]     last_j_s;
    logic [DWIDTH-1:0]   lo_s, hi_s, head_s;

    assign accept_s    = snk_if.valid & snk_ready_q;
    assign send_s      = src_valid_q & src_if.ready;
    assign j_nxt_s     = j_q + AWIDTH'(1);
    assign wr_idx_s    = len_q[AWIDTH-1:0];
    assign last_j_s    = len_q - (AWIDTH+1)'(2) - {1'b0, pass_q};
    assign pass_end_s  = ({1'b0, j_q} == last_j_s);
    assign last_pass_s = ({1'b0, pass_q} == (len_q - (AWIDTH+1)'(2)));

    packet_sorter_cmp #(.DWIDTH(DWIDTH)) u_cmp (
        .a_i    (mem_q[j_q]),
        .b_i    (mem_q[j_nxt_s]),
        .dir_i  (dir_q),
        .lo_o   (lo_s),
        .hi_o   (hi_s),
        .swap_o (swap_s)
    );

    // End-of-sort decision and the index-0 word as it stands after this cycle's swap.
    always_comb begin
        done_s = last_pass_s;
        head_s = mem_q[0];
`ifdef PACKET_SORTER_EARLY_EXIT_EN
        done_s = last_pass_s | ~(pass_swap_q | swap_s);
`endif
        if (j_q == AWIDTH'(0)) begin
            head_s = lo_s;
        end else begin
            head_s = mem_q[0];
        end
    end

    // Receive / sort / send state machine with registered stream outputs.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= RECV;
            len_q       <= '0;
            j_q         <= '0;
            pass_q      <= '0;
            rd_idx_q    <= '0;
            dir_q       <= DIR_ASC;
            in_pkt_q    <= 1'b0;
            ovf_seen_q  <= 1'b0;
            pass_swap_q <= 1'b0;
            snk_ready_q <= 1'b1;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_data_q  <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef PACKET_SORTER_EARLY_EXIT_EN
            swaps_q     <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ovf_q <= 1'b0;
            case (state_q)
                RECV: begin
                    if (accept_s && snk_if.startofpacket) begin
                        mem_q[0]   <= snk_if.data;
                        len_q      <= (AWIDTH+1)'(1);
                        dir_q      <= dir_i;
                        in_pkt_q   <= ~snk_if.endofpacket;
                        ovf_seen_q <= 1'b0;
                        if (snk_if.endofpacket) begin
                            state_q     <= SEND;
                            snk_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            src_valid_q <= 1'b1;
                            src_sop_q   <= 1'b1;
                            src_eop_q   <= 1'b1;
                            src_data_q  <= snk_if.data;
                            rd_idx_q    <= AWIDTH'(1);
                        end
                    end else if (accept_s && in_pkt_q) begin
                        if (len_q < DEPTH_L) begin
                            mem_q[wr_idx_s] <= snk_if.data;
                            len_q           <= len_q + (AWIDTH+1)'(1);
                        end else if (!ovf_seen_q) begin
                            ovf_q      <= 1'b1;
                            ovf_seen_q <= 1'b1;
                        end
                        // A non-sop eop always leaves at least two words.
                        if (snk_if.endofpacket) begin
                            state_q     <= SORT;
                            in_pkt_q    <= 1'b0;
                            snk_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            j_q         <= '0;
                            pass_q      <= '0;
                            pass_swap_q <= 1'b0;
`ifdef PACKET_SORTER_EARLY_EXIT_EN
                            swaps_q     <= '0;
`endif
                        end
                    end
                end
                SORT: begin
                    mem_q[j_q]     <= lo_s;
                    mem_q[j_nxt_s] <= hi_s;
`ifdef PACKET_SORTER_EARLY_EXIT_EN
                    if (swap_s) begin
                        swaps_q <= swaps_q + (2*AWIDTH)'(1);
                    end
`endif
                    if (pass_end_s && done_s) begin
                        state_q     <= SEND;
                        src_valid_q <= 1'b1;
                        src_sop_q   <= 1'b1;
                        src_eop_q   <= 1'b0;
                        src_data_q  <= head_s;
                        rd_idx_q    <= AWIDTH'(1);
                    end else if (pass_end_s) begin
                        pass_q      <= pass_q + AWIDTH'(1);
                        j_q         <= '0;
                        pass_swap_q <= 1'b0;
                    end else begin
                        j_q         <= j_nxt_s;
                        pass_swap_q <= pass_swap_q | swap_s;
                    end
                end
                SEND: begin
                    if (send_s && src_eop_q) begin
                        state_q     <= RECV;
                        len_q       <= '0;
                        src_valid_q <= 1'b0;
                        src_sop_q   <= 1'b0;
                        src_eop_q   <= 1'b0;
                        src_data_q  <= '0;
                        snk_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) begin
                            mem_q[i] <= '0;
                        end
                    end else if (send_s) begin
                        src_data_q <= mem_q[rd_idx_q];
                        src_sop_q  <= 1'b0;
                        src_eop_q  <= ({1'b0, rd_idx_q} == (len_q - (AWIDTH+1)'(1)));
                        rd_idx_q   <= rd_idx_q + AWIDTH'(1);
                    end
                end
                default: begin
                    state_q <= RECV;
                end
            endcase
        end
    end

    assign snk_if.ready         = snk_ready_q;
    assign src_if.valid         = src_valid_q;
    assign src_if.data          = src_data_q;
    assign src_if.startofpacket = src_sop_q;
    assign src_if.endofpacket   = src_eop_q;
    assign busy_o               = busy_q;
    assign ovf_o                = ovf_q;
`ifdef PACKET_SORTER_EARLY_EXIT_EN
    assign swaps_o              = swaps_q;
`endif

endmodule

// File: tb/tb_packet_sorter.sv
// Directed bench for packet_sorter: framing, both directions, overflow, backpressure, reset.
module tb_packet_sorter;
    import packet_sorter_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic dir = 1'b0;
    logic busy, ovf;
`ifdef PACKET_SORTER_EARLY_EXIT_EN
    logic [2*AW-1:0] swaps;
`endif

    always #5 clk = ~clk;

    packet_sorter_if #(.DWIDTH(DW)) snk_if ();
    packet_sorter_if #(.DWIDTH(DW)) src_if ();

    packet_sorter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .dir_i    (dir),
        .snk_if   (snk_if),
        .src_if   (src_if),
        .busy_o   (busy),
        .ovf_o    (ovf)
`ifdef PACKET_SORTER_EARLY_EXIT_EN
        ,
        .swaps_o  (swaps)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int ovf_cnt = 0;
    int lat;

    logic [7:0] in_d [0:31];
    bit         in_s [0:31];
    bit         in_e [0:31];
    int         in_n = 0;
    logic [7:0] exp_d [0:31];
    int         exp_n = 0;
    logic [7:0] out_d [0:31];
    bit         out_s [0:31];
    bit         out_e [0:31];
    int         out_n = 0;

    localparam logic [14:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [14:0] out_vec();
        return {snk_if.ready, src_if.valid, src_if.startofpacket, src_if.endofpacket,
                busy, ovf, src_if.data, 1'b0};
    endfunction

    task automatic put(input logic [7:0] d, input bit s, input bit e);
        in_d[in_n] = d;
        in_s[in_n] = s;
        in_e[in_n] = e;
        in_n++;
    endtask

    task automatic want(input logic [7:0] d);
        exp_d[exp_n] = d;
        exp_n++;
    endtask

    task automatic send(input logic d);
        ovf_cnt = 0;
        for (int k = 0; k < in_n; k++) begin
            @(negedge clk);
            ovf_cnt += int'(ovf);
            snk_if.valid         = 1'b1;
            snk_if.data          = in_d[k];
            snk_if.startofpacket = in_s[k];
            snk_if.endofpacket   = in_e[k];
            dir                  = d;
        end
        @(negedge clk);
        ovf_cnt += int'(ovf);
        snk_if.valid         = 1'b0;
        snk_if.startofpacket = 1'b0;
        snk_if.endofpacket   = 1'b0;
        in_n = 0;
    endtask

    task automatic wait_valid(output int l);
        int k = 0;
        while (src_if.valid !== 1'b1 && k < 300) begin
            @(negedge clk);
            ovf_cnt += int'(ovf);
            k++;
        end
        l = k + 1;
    endtask

    task automatic collect(input bit rnd);
        int cyc = 0;
        bit done = 1'b0;
        bit stalled = 1'b0;
        bit rdy;
        logic [9:0] held = '0;
        out_n = 0;
        while (!done && cyc < 400) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (src_if.valid === 1'b1) begin
                if (stalled) begin
                    check("stall_hold", {src_if.startofpacket, src_if.endofpacket, src_if.data}, held);
                end
                if (rdy) begin
                    out_d[out_n] = src_if.data;
                    out_s[out_n] = src_if.startofpacket;
                    out_e[out_n] = src_if.endofpacket;
                    if (out_n < 31) out_n++;
                    done    = src_if.endofpacket;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = {src_if.startofpacket, src_if.endofpacket, src_if.data};
                end
            end
            src_if.ready = rdy;
            @(negedge clk);
            ovf_cnt += int'(ovf);
            cyc++;
        end
        src_if.ready = 1'b1;
        check("collect_done", done, 1);
    endtask

    task automatic verify(input string tag);
        check($sformatf("%s_count", tag), out_n, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            check($sformatf("%s_data%0d", tag, k), out_d[k], exp_d[k]);
            check($sformatf("%s_frame%0d", tag, k), {out_s[k], out_e[k]},
                  {(k == 0), (k == exp_n - 1)});
        end
        check($sformatf("%s_idle", tag), {src_if.valid, snk_if.ready, busy}, 3'b010);
        exp_n = 0;
    endtask

    initial begin
        logic [7:0] r [0:15];
        logic [7:0] t;
        logic [7:0] perm [0:15];
        snk_if.valid = 1'b0;
        snk_if.data = '0;
        snk_if.startofpacket = 1'b0;
        snk_if.endofpacket = 1'b0;
        src_if.ready = 1'b1;

        // Reset values, in and out of reset
        repeat (2) @(negedge clk);
        check("reset", out_vec(), RST_VEC);
        arst_n = 1'b1;
        @(negedge clk);
        check("post_reset", out_vec(), RST_VEC);

        // 1: ascending 3,1,2,0
        put(8'd3, 1, 0); put(8'd1, 0, 0); put(8'd2, 0, 0); put(8'd0, 0, 1);
        send(DIR_ASC);
        check("t1_busy_after_eop", {busy, snk_if.ready}, 2'b10);
        wait_valid(lat);
        check("t1_latency", lat, 7);
`ifdef PACKET_SORTER_EARLY_EXIT_EN
        check("t1_swaps", swaps, 5);
`endif
        want(8'd0); want(8'd1); want(8'd2); want(8'd3);
        collect(0);
        check("t1_no_ovf", ovf_cnt, 0);
        verify("t1");

        // 2: descending, with a sop restart after two stale words
        put(8'd7, 1, 0); put(8'd8, 0, 0);
        put(8'd5, 1, 0); put(8'd9, 0, 0); put(8'd5, 0, 0); put(8'd1, 0, 1);
        send(DIR_DESC);
        wait_valid(lat);
        want(8'd9); want(8'd5); want(8'd5); want(8'd1);
        collect(0);
        verify("t2");

        // 3: stray word before sop, then single-beat packet
        put(8'h55, 0, 1); put(8'hAA, 1, 1);
        send(DIR_ASC);
        wait_valid(lat);
        check("t3_latency", lat, 1);
        want(8'hAA);
        collect(0);
        verify("t3");

        // 4: 18 words, last two dropped
        perm = '{8'd9, 8'd2, 8'd14, 8'd7, 8'd0, 8'd11, 8'd4, 8'd13,
                 8'd6, 8'd1, 8'd15, 8'd8, 8'd3, 8'd10, 8'd5, 8'd12};
        for (int k = 0; k < 16; k++) put(perm[k], (k == 0), 0);
        put(8'hF0, 0, 0); put(8'h80, 0, 1);
        send(DIR_ASC);
        wait_valid(lat);
`ifndef PACKET_SORTER_EARLY_EXIT_EN
        check("t4_latency", lat, 121);
`endif
        for (int k = 0; k < 16; k++) want(8'(k));
        collect(0);
        check("t4_ovf_pulses", ovf_cnt, 1);
        verify("t4");

        // 5: 16 random words under random backpressure
        for (int k = 0; k < 16; k++) begin
            r[k] = 8'($urandom_range(0, 255));
            put(r[k], (k == 0), (k == 15));
        end
        for (int a = 1; a < 16; a++) begin
            for (int b = a; b > 0 && r[b-1] > r[b]; b--) begin
                t = r[b]; r[b] = r[b-1]; r[b-1] = t;
            end
        end
        for (int k = 0; k < 16; k++) want(r[k]);
        send(DIR_ASC);
        wait_valid(lat);
        collect(1);
        verify("t5");

        // 6: reset during SORT, then a fresh packet
        for (int k = 0; k < 8; k++) put(8'(8 - k), (k == 0), (k == 7));
        send(DIR_ASC);
        repeat (5) @(negedge clk);
        check("t6_sorting", {busy, snk_if.ready, src_if.valid}, 3'b100);
        arst_n = 1'b0;
        #1;
        check("t6_async_reset", out_vec(), RST_VEC);
        @(negedge clk);
        arst_n = 1'b1;
        put(8'd2, 1, 0); put(8'd0, 0, 0); put(8'd1, 0, 1);
        send(DIR_ASC);
        wait_valid(lat);
        check("t6_latency", lat, 4);
        want(8'd0); want(8'd1); want(8'd2);
        collect(0);
        verify("t6");

        // 7: already-sorted 1..8
        for (int k = 0; k < 8; k++) put(8'(k + 1), (k == 0), (k == 7));
        send(DIR_ASC);
        wait_valid(lat);
`ifdef PACKET_SORTER_EARLY_EXIT_EN
        check("t7_latency", lat, 8);
        check("t7_swaps", swaps, 0);
`else
        check("t7_latency", lat, 29);
`endif
        for (int k = 0; k < 8; k++) want(8'(k + 1));
        collect(0);
        verify("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
